// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected neuron scheduler.
//   fc_state_t  : scheduler FSM encoding (exported on the debug port fsm_state)
//   fc_sat_max  : largest positive value of a signed w-bit result, 2^(w-1)-1,
//                 the clamp applied by the activation step
package fc_pkg;

  localparam int FC_STATE_W = 3;

  typedef enum logic [FC_STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_ACT   = 3'd3,
    ST_OUT   = 3'd4,
    ST_FIN   = 3'd5
  } fc_state_t;

  // Saturation ceiling for a signed result of width w.
  function automatic longint fc_sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Signed multiply-accumulate shared by every neuron of the layer.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the accumulator (takes priority over en)
//   en         : add the full-precision product a*b this cycle
//   a, b       : signed W-bit operands
//   acc        : signed ACC_WIDTH-bit running sum
module fc_mac
  import fc_pkg::*;
#(
  parameter int W         = 8,
  parameter int ACC_WIDTH = 2 * W + 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  output logic [ACC_WIDTH-1:0] acc
);

  logic signed [2*W-1:0]       product;
  logic signed [ACC_WIDTH-1:0] product_ext;

  // Full 2W-bit signed product, sign-extended so the sum never truncates.
  assign product     = $signed(a) * $signed(b);
  assign product_ext = {{(ACC_WIDTH - 2 * W){product[2*W-1]}}, product};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + product_ext;
    end
  end

endmodule

// File: rtl/fc_neuron_scheduler.sv
// Sequences one fully-connected layer: for each neuron it streams IN_SIZE
// input/weight pairs from memory through a single time-shared MAC, adds the
// neuron's bias, applies a clamped ReLU, and presents the result on a
// valid/ready output.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : begin a layer (only looked at in IDLE)
//   busy              : high in every state except IDLE
//   done              : one-cycle pulse after the last neuron's result is taken
//   rd_en             : memory read strobe; in_data/w_data valid one cycle later
//   in_addr, w_addr   : input element index and weight index n*IN_SIZE+k
//   in_data, w_data   : signed read data
//   biases_flat       : bias of neuron n at bits [n*W +: W]
//   out_valid/ready   : result handshake, out_idx = neuron, out_data = result
//   fsm_state         : current scheduler state (debug visibility)
//
// Output handshake: a result transfers on a rising clk edge where
// out_valid && out_ready. Once out_valid rises it stays high, and out_idx /
// out_data stay unchanged, until that transfer; out_valid never depends
// combinationally on out_ready.
module fc_neuron_scheduler
  import fc_pkg::*;
#(
  parameter int IN_SIZE   = 256,
  parameter int OUT_SIZE  = 8,
  parameter int W         = 8,
  parameter int ACC_WIDTH = 2 * W + $clog2(IN_SIZE) + 1,
  localparam int K_W      = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1,
  localparam int A_W      = (OUT_SIZE * IN_SIZE > 1) ? $clog2(OUT_SIZE * IN_SIZE) : 1,
  localparam int N_W      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [K_W-1:0]        in_addr,
  output logic [A_W-1:0]        w_addr,
  input  logic [W-1:0]          in_data,
  input  logic [W-1:0]          w_data,
  input  logic [W*OUT_SIZE-1:0] biases_flat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_W-1:0]        out_idx,
  output logic [W-1:0]          out_data,
  output logic [FC_STATE_W-1:0] fsm_state
);

  localparam logic [K_W-1:0] K_LAST = K_W'(IN_SIZE - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(OUT_SIZE - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_ACC = ACC_WIDTH'(fc_sat_max(W));

  fc_state_t                   state;
  logic [K_W-1:0]              k;
  logic [N_W-1:0]              n;
  logic                        rd_q;
  logic                        mac_clear;
  logic [ACC_WIDTH-1:0]        acc;
  logic [W-1:0]                bias_n;
  logic signed [ACC_WIDTH-1:0] sum;
  logic [W-1:0]                act_result;

  assign in_addr   = k;
  assign fsm_state = state;

  // Read data lands one cycle after each strobe, so the MAC enable is the
  // strobe delayed by a cycle; DRAIN exists to absorb the last product.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= 1'b0;
    end else begin
      rd_q <= rd_en;
    end
  end

  // The accumulator is zeroed on the same edge a neuron's FETCH begins.
  assign mac_clear = ((state == ST_IDLE) && start) ||
                     ((state == ST_OUT) && out_ready && (n != N_LAST));

  fc_mac #(
    .W        (W),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .clear(mac_clear),
    .en   (rd_q),
    .a    (in_data),
    .b    (w_data),
    .acc  (acc)
  );

  // Bias add and clamped ReLU: non-positive -> 0, above the signed ceiling
  // -> ceiling, otherwise the low W bits (already known to fit).
  assign bias_n = biases_flat[n*W +: W];
  assign sum    = $signed(acc) + $signed({{(ACC_WIDTH - W){bias_n[W-1]}}, bias_n});

  always_comb begin
    act_result = '0;
    if (sum <= 0) begin
      act_result = '0;
    end else if (sum > SAT_ACC) begin
      act_result = SAT_ACC[W-1:0];
    end else begin
      act_result = sum[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      k         <= '0;
      n         <= '0;
      w_addr    <= '0;
      rd_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_FETCH;
            busy   <= 1'b1;
            rd_en  <= 1'b1;
            k      <= '0;
            n      <= '0;
            w_addr <= '0;
          end
        end

        ST_FETCH: begin
          if (k == K_LAST) begin
            rd_en <= 1'b0;
            state <= ST_DRAIN;
          end else begin
            k      <= k + 1'b1;
            w_addr <= w_addr + 1'b1;
          end
        end

        ST_DRAIN: begin
          state <= ST_ACT;
        end

        ST_ACT: begin
          out_data  <= act_result;
          out_idx   <= n;
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end

        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (n == N_LAST) begin
              done  <= 1'b1;
              state <= ST_FIN;
            end else begin
              // w_addr sits on the previous neuron's last weight, so +1 is
              // exactly (n+1)*IN_SIZE.
              n      <= n + 1'b1;
              k      <= '0;
              w_addr <= w_addr + 1'b1;
              rd_en  <= 1'b1;
              state  <= ST_FETCH;
            end
          end
        end

        ST_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fc_neuron_scheduler.md
FC_NEURON_SCHEDULER -- requirements
Module: fc_neuron_scheduler

Interface
REQ-001 SHALL have parameter IN_SIZE, default 256, input vector length.
REQ-002 SHALL have parameter OUT_SIZE, default 8, number of neurons.
REQ-003 SHALL have parameter W, default 8, signed data/weight/bias width.
REQ-004 SHALL have parameter ACC_WIDTH, default 2*W+$clog2(IN_SIZE)+1, signed accumulator width.
REQ-005 SHALL have port clk  input  1  clock; reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin one layer evaluation (sampled in IDLE only).
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse after last neuron accepted.
REQ-009 SHALL have port rd_en  output  1  memory read strobe; data returned exactly one cycle later.
REQ-010 SHALL have port in_addr  output  $clog2(IN_SIZE)  input-vector element index.
REQ-011 SHALL have port w_addr  output  $clog2(OUT_SIZE*IN_SIZE)  weight index = neuron*IN_SIZE + element.
REQ-012 SHALL have port in_data, w_data  input  W each  signed read data.
REQ-013 SHALL have port biases_flat  input  W*OUT_SIZE  signed bias of neuron n at bits [n*W +: W].
REQ-014 SHALL have port out_valid  output  1; out_ready  input  1; out_idx  output  $clog2(OUT_SIZE); out_data  output  W.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, DRAIN, ACT, OUT, FIN.
REQ-016 IDLE -> FETCH on start=1; neuron counter n=0, element counter k=0, accumulator cleared.
REQ-017 FETCH: rd_en=1 for IN_SIZE consecutive cycles, addresses k and n*IN_SIZE+k, k incrementing; after k=IN_SIZE-1 -> DRAIN.
REQ-018 Each cycle following an rd_en cycle, accumulator SHALL add sign-extended in_data*w_data (full 2W product, no truncation).
REQ-019 DRAIN: one cycle absorbing the final product, rd_en=0; -> ACT.
REQ-020 ACT: sum = acc + sign-extended bias n; result = 0 if sum<=0, 2^(W-1)-1 if sum>2^(W-1)-1, else sum[W-1:0]; register into out_data, out_idx=n; -> OUT.
REQ-021 OUT: out_valid=1, out_data/out_idx stable until out_valid&&out_ready; on transfer: if n=OUT_SIZE-1 -> FIN, else n+1, k=0, acc=0, -> FETCH.
REQ-022 FIN: done=1 one cycle; -> IDLE.
REQ-023 Per-neuron latency with out_ready held high: IN_SIZE+3 cycles (FETCH..OUT inclusive); full layer OUT_SIZE*(IN_SIZE+3)+1 cycles start-accept to done.
REQ-024 start while busy SHALL be ignored; start in FIN cycle ignored; start must re-assert in IDLE.
REQ-025 rd_en, out_valid, done SHALL be 0 in IDLE; in_addr/w_addr SHALL hold last value when rd_en=0.
REQ-026 Accumulator SHALL never overflow for any in/w/bias values at default ACC_WIDTH.

Reset
REQ-027 reset SHALL force IDLE, n=k=0, acc=0, busy=0, done=0, rd_en=0, out_valid=0, out_idx=0, out_data=0, addresses 0.
REQ-028 reset mid-operation SHALL abandon the layer with no further out_valid or done; reset dominates start in the same cycle.

Structure
REQ-029 State encoding enum and the saturation constant 2^(W-1)-1 SHALL live in a shared package fc_pkg.
REQ-030 The multiply-accumulate SHALL be a sub-module fc_mac (clear, en, a, b -> acc), instantiated once and time-shared across neurons.

Verification (bench params IN_SIZE=4, OUT_SIZE=2, W=8)
REQ-031 in=[1,2,3,4], row0=[1,1,1,1], row1=[-1,-1,-1,-1], biases=[5,0], out_ready=1 -> out (0,15),(1,0); done 15 cycles after start.
REQ-032 in=[127,127,127,127], row0=[127,127,127,127], bias0=0 -> out_data 127 (saturated, sum 64516).
REQ-033 in=[-128 x4], row0=[-128 x4], bias0=-128 -> sum 65408, out_data 127; row1=[127 x4], bias1=-128 -> sum -65152, out_data 0.
REQ-034 out_ready low 5 cycles during neuron 0 OUT -> out_valid held, out_data/out_idx stable, rd_en 0, total latency +5.
REQ-035 reset asserted during FETCH of neuron 1 -> next cycle busy=0, rd_en=0, no done; new start gives correct full result.
REQ-036 start pulsed during FETCH and during FIN -> exactly one done, no second evaluation.
